io_port: RTL and testbench
==========================

# io_port

Memory-mapped I/O port of the cdecv memory subsystem, directly downstream of the address decoder. It consumes the decoder's `we_io` and `sel_ram_io` outputs and does three things:
- latches CPU stores to the I/O address (0xFF) into an 8-bit output register that drives LEDs and the monitor;
- synchronizes and debounces the 8-bit switch input;
- muxes the load data returned to the CPU between RAM and the debounced input.

A sticky change flag tells the monitor that the input moved since the CPU last loaded it.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 1000: number of consecutive cycles the synchronized input must hold one value before it is accepted. Legal range is ≥1.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `we_io`  in  1  store strobe to I/O, from the address decoder.
- `sel_ram_io`  in  1  1 selects I/O (MA = 0xFF), 0 selects RAM, from the address decoder.
- `re`  in  1  CPU load strobe, one cycle per load instruction.
- `WD`  in  8  CPU store data.
- `ram_rd`  in  8  RAM read data.
- `sw_in`  in  8  asynchronous switch inputs.
- `RD`  out  8  load data to the CPU.
- `io_out`  out  8  output register, drives LEDs and the monitor.
- `io_in`  out  8  debounced input value, for the monitor.
- `io_changed`  out  1  sticky flag: accepted input differs from the value last loaded by the CPU.

## Operation
- **Output register.** On an edge with `we_io`=1, `io_out` ← `WD`. Otherwise `io_out` holds its value.
- **Synchronizer.** Two flops, `sync1` ← `sw_in` and `sync2` ← `sync1`, all 8 bits together.
- **Debouncer.** Registers `cand` and `cnt`, evaluated on each edge in priority order:
  1. `sync2`≠`cand`: `cand` ← `sync2`, `cnt` ← 0.
  2. `cnt` = `DEBOUNCE_CYCLES`−1: `io_in` ← `cand`; `cnt` holds (saturates).
  3. Otherwise: `cnt` ← `cnt`+1.
- **Debouncer properties.**
  - A bounce shorter than `DEBOUNCE_CYCLES` cycles never reaches `io_in`.
  - `cnt` width is max(1, $clog2(`DEBOUNCE_CYCLES`)); `cnt` never wraps.
- **Change flag.**
  - Set on an edge where `io_in` is loaded with a value different from its current value.
  - Cleared on an edge with `re`=1 and `sel_ram_io`=1.
  - If set and clear occur on the same edge, set wins.
- **Read mux** (combinational): `RD` = `sel_ram_io` ? `io_in` : `ram_rd`.
- **Output-path independence.** The output register never feeds back into `RD`. A load from 0xFF always returns the switches, never `io_out`.
- **Reset.** While `reset_n`=0, `io_out`, `sync1`, `sync2`, `cand`, `cnt`, `io_in` and `io_changed` are all 0. Reset in mid-debounce discards the candidate; debouncing restarts from 0 after release.

## Timing
- **Store.** `io_out` reflects `WD` one cycle after the edge sampling `we_io`=1.
- **Load.** `RD` is zero-latency: it is valid in the same cycle as `sel_ram_io`, with no register in the path.
- **Input latency.** For `sw_in` stable from before edge 0:
  - `sync2` updates at edge 1.
  - `cand` updates at edge 2.
  - `io_in` and `io_changed` update at edge 2+`DEBOUNCE_CYCLES`.
- **Back-to-back stores.** Consecutive `we_io` cycles each update `io_out`, and the last write wins.
- **Stores and the flag.** `we_io` has no effect on `io_changed`.
- **Flag clearing.** A load from 0xFF with `re`=1 clears `io_changed` at that edge. The flag reads 0 from the next cycle unless a new accepted change coincides with the clear.

## Structure
- **Shared package** `cdecv_pkg` holds:
  - `IO_ADDR` = 8'hFF;
  - `DATA_W` = 8;
  - `addr_t`/`data_t` typedefs.

  The address decoder and this block both use `IO_ADDR`.
- **Sub-module** `io_debouncer` (parameter `DEBOUNCE_CYCLES`, width `DATA_W`) contains the synchronizer, `cand`, `cnt` and `io_in`, and emits a one-cycle `accepted_change` pulse.
- **Top level** `io_port` holds `io_out`, `io_changed` and the `RD` mux.

## Test plan
1. **Reset.** Assert `reset_n`=0 mid-run with `sw_in`=8'hA5 and `io_out`=8'h3C → all outputs 0 during reset. After release, `io_in`=8'hA5 at release edge 2+N.
2. **Store and load.** `we_io`=1 with `WD`=8'h5A at edge k → `io_out`=8'h5A after edge k. Then `sel_ram_io`=1 with `sw_in`=8'h00 settled → `RD`=8'h00. With `sel_ram_io`=0 and `ram_rd`=8'h77 → `RD`=8'h77.
3. **Debounce accept** (N=4). `sw_in` goes 8'h00→8'h81 before edge 0 → `io_in`=8'h81 and `io_changed`=1 at edge 6, not at edge 5.
4. **Bounce reject** (N=4). `sw_in` pulses to 8'hFF for 3 cycles, then returns to 8'h00 → `io_in` stays 8'h00 and `io_changed` stays 0.
5. **Flag clear and set collision.**
   - Load from 0xFF (`re`=1, `sel_ram_io`=1) → `io_changed` clears next cycle.
   - Repeat with the clear on the same edge as a new accept → `io_changed` stays 1.
6. **Saturation.** N=1, `sw_in` held constant for 300 cycles → `cnt` stays 0, with no spurious `io_changed` after the first accept.

Source files
------------

// File: rtl/cdecv_pkg.sv
// Shared definitions for the cdecv memory subsystem: data/address widths and the I/O address.
package cdecv_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 8;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;

    localparam addr_t IO_ADDR = 8'hFF;

endpackage

// File: rtl/io_debouncer.sv
// Two-flop synchronizer plus hold-time debouncer for the switch inputs.
// accepted_change_c is high on the edge that loads io_in with a new value.
module io_debouncer
    import cdecv_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
    input  logic  clk,
    input  logic  reset_n,
    input  data_t sw_in,
    output data_t io_in,
    output logic  accepted_change_c
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    data_t            sync1_q, sync2_q;
    data_t            cand_q, cand_d;
    data_t            io_in_q, io_in_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stable_c;
    logic             at_max_c;

    // Restart on any candidate change, accept once held long enough, saturate after.
    always_comb begin
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        io_in_d  = io_in_q;
        stable_c = (sync2_q == cand_q);
        at_max_c = (cnt_q == CNT_MAX);
        if (!stable_c) begin
            cand_d = sync2_q;
            cnt_d  = '0;
        end else if (at_max_c) begin
            io_in_d = cand_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        accepted_change_c = stable_c && at_max_c && (cand_q != io_in_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            cand_q  <= '0;
            cnt_q   <= '0;
            io_in_q <= '0;
        end else begin
            sync1_q <= sw_in;
            sync2_q <= sync1_q;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            io_in_q <= io_in_d;
        end
    end

    assign io_in = io_in_q;

endmodule

// File: rtl/io_port.sv
// Memory-mapped I/O port at IO_ADDR: LED output register, debounced switch input,
// load-data mux and a sticky input-changed flag for the monitor.
module io_port
    import cdecv_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
    input  logic  clk,
    input  logic  reset_n,
    input  logic  we_io,
    input  logic  sel_ram_io,
    input  logic  re,
    input  data_t WD,
    input  data_t ram_rd,
    input  data_t sw_in,
    output data_t RD,
    output data_t io_out,
    output data_t io_in,
    output logic  io_changed
);

    data_t io_out_q, io_out_d;
    logic  io_changed_q, io_changed_d;
    data_t io_in_w;
    logic  accepted_change_c;

    io_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
        .clk               (clk),
        .reset_n           (reset_n),
        .sw_in             (sw_in),
        .io_in             (io_in_w),
        .accepted_change_c (accepted_change_c)
    );

    // A new accept overrides a CPU load clearing the flag on the same edge.
    always_comb begin
        io_out_d     = io_out_q;
        io_changed_d = io_changed_q;
        if (we_io) begin
            io_out_d = WD;
        end
        if (re && sel_ram_io) begin
            io_changed_d = 1'b0;
        end
        if (accepted_change_c) begin
            io_changed_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            io_out_q     <= '0;
            io_changed_q <= 1'b0;
        end else begin
            io_out_q     <= io_out_d;
            io_changed_q <= io_changed_d;
        end
    end

    // Loads from the I/O address always return the switches, never io_out.
    assign RD         = sel_ram_io ? io_in_w : ram_rd;
    assign io_out     = io_out_q;
    assign io_in      = io_in_w;
    assign io_changed = io_changed_q;

endmodule

// File: tb/tb_io_port.sv
// Directed bench for io_port: one instance with DEBOUNCE_CYCLES=4, one with DEBOUNCE_CYCLES=1.
module tb_io_port;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       we_io, sel_ram_io, re;
    logic [7:0] WD, ram_rd, sw_in, sw_in1;
    logic [7:0] RD, io_out, io_in;
    logic       io_changed;
    logic [7:0] RD1, io_out1, io_in1;
    logic       io_changed1;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    io_port #(.DEBOUNCE_CYCLES(4)) dut (
        .clk(clk), .reset_n(reset_n), .we_io(we_io), .sel_ram_io(sel_ram_io), .re(re),
        .WD(WD), .ram_rd(ram_rd), .sw_in(sw_in),
        .RD(RD), .io_out(io_out), .io_in(io_in), .io_changed(io_changed)
    );

    io_port #(.DEBOUNCE_CYCLES(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .we_io(we_io), .sel_ram_io(sel_ram_io), .re(re),
        .WD(WD), .ram_rd(ram_rd), .sw_in(sw_in1),
        .RD(RD1), .io_out(io_out1), .io_in(io_in1), .io_changed(io_changed1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    // Advance one rising edge; inputs change and outputs are sampled 1ns after it.
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic bad;
        reset_n = 1'b0; we_io = 1'b0; sel_ram_io = 1'b1; re = 1'b0;
        WD = 8'h00; ram_rd = 8'h00; sw_in = 8'h00; sw_in1 = 8'h00;
        tick(2);
        check("rst_io_out", 32'(io_out), 32'h0);
        check("rst_io_in", 32'(io_in), 32'h0);
        check("rst_flag", 32'(io_changed), 32'h0);
        check("rst_rd", 32'(RD), 32'h0);
        reset_n = 1'b1;
        tick(10);
        check("idle_io_in", 32'(io_in), 32'h0);
        check("idle_flag", 32'(io_changed), 32'h0);

        // Store, back-to-back stores, and the load mux
        we_io = 1'b1; WD = 8'h5A;
        tick();
        we_io = 1'b0;
        check("store_5a", 32'(io_out), 32'h5A);
        we_io = 1'b1; WD = 8'h11;
        tick();
        WD = 8'h22;
        tick();
        we_io = 1'b0;
        check("b2b_store", 32'(io_out), 32'h22);
        check("store_no_flag", 32'(io_changed), 32'h0);
        sel_ram_io = 1'b1;
        #1 check("rd_io", 32'(RD), 32'h00);
        sel_ram_io = 1'b0; ram_rd = 8'h77;
        #1 check("rd_ram", 32'(RD), 32'h77);

        // Bounce of 3 cycles must be rejected
        sw_in = 8'hFF;
        tick(3);
        sw_in = 8'h00;
        bad = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (io_in !== 8'h00 || io_changed !== 1'b0) bad = 1'b1;
        end
        check("bounce_reject", 32'(bad), 32'h0);

        // Accept lands at edge 2+N=6, not edge 5
        sw_in = 8'h81;
        tick(6);
        check("accept_e5_io_in", 32'(io_in), 32'h00);
        check("accept_e5_flag", 32'(io_changed), 32'h0);
        tick();
        check("accept_e6_io_in", 32'(io_in), 32'h81);
        check("accept_e6_flag", 32'(io_changed), 32'h1);
        sel_ram_io = 1'b1;
        #1 check("rd_switch_not_out", 32'(RD), 32'h81);

        // Load from the I/O address clears the flag
        re = 1'b1;
        tick();
        re = 1'b0;
        check("flag_clear", 32'(io_changed), 32'h0);

        // Clear on the same edge as a new accept: set wins
        sw_in = 8'h42;
        tick(6);
        check("collide_pre_io_in", 32'(io_in), 32'h81);
        re = 1'b1;
        tick();
        re = 1'b0;
        check("collide_io_in", 32'(io_in), 32'h42);
        check("collide_flag", 32'(io_changed), 32'h1);
        re = 1'b1;
        tick();
        re = 1'b0;
        check("collide_reclear", 32'(io_changed), 32'h0);

        // Mid-run reset discards the candidate and restarts debouncing
        sw_in = 8'hA5; we_io = 1'b1; WD = 8'h3C;
        tick();
        we_io = 1'b0;
        check("pre_rst_out", 32'(io_out), 32'h3C);
        reset_n = 1'b0;
        #1;
        check("midrst_io_out", 32'(io_out), 32'h0);
        check("midrst_io_in", 32'(io_in), 32'h0);
        check("midrst_flag", 32'(io_changed), 32'h0);
        check("midrst_rd", 32'(RD), 32'h0);
        tick(3);
        reset_n = 1'b1;
        tick(6);
        check("rel_e5_io_in", 32'(io_in), 32'h00);
        tick();
        check("rel_e6_io_in", 32'(io_in), 32'hA5);
        check("rel_e6_flag", 32'(io_changed), 32'h1);

        // N=1: accept at edge 3, then saturate with no spurious flag
        sw_in1 = 8'hC3;
        tick(3);
        check("n1_e2_io_in", 32'(io_in1), 32'h00);
        tick();
        check("n1_e3_io_in", 32'(io_in1), 32'hC3);
        check("n1_e3_flag", 32'(io_changed1), 32'h1);
        re = 1'b1;
        tick();
        re = 1'b0;
        check("n1_clear", 32'(io_changed1), 32'h0);
        bad = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (io_changed1 !== 1'b0 || io_in1 !== 8'hC3) bad = 1'b1;
        end
        check("n1_sat_stable", 32'(bad), 32'h0);
        check("n1_cnt_zero", 32'(dut1.u_deb.cnt_q), 32'h0);
        sel_ram_io = 1'b0; ram_rd = 8'h19;
        #1 check("n1_rd_ram", 32'(RD1), 32'h19);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
